// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the LC-3b in-order pipe: per-stage load enables, valid bits,
// NOP injection, load-use interlock, WB-redirect flush, cache stall arbitration, perf counters.
module pipe_hazard_ctrl #(
  parameter int STAGES    = 5,
  parameter int MEM_STAGE = STAGES - 2,
  parameter int REGW      = 3,
  parameter int CNTW      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_resp,
  input  logic              d_mem_req,
  input  logic              d_mem_resp,
  input  logic [REGW-1:0]   id_src_a,
  input  logic [REGW-1:0]   id_src_b,
  input  logic              id_src_a_used,
  input  logic              id_src_b_used,
  input  logic [REGW-1:0]   ex_dest,
  input  logic              ex_load,
  input  logic              redirect,
  output logic [STAGES-1:0] stage_load,
  output logic [STAGES-1:0] bubble,
  output logic [STAGES-1:0] stage_valid,
  output logic              i_mem_read,
  output logic              retire,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   flush_cnt,
  output logic [CNTW-1:0]   retire_cnt
);

  localparam int WB = STAGES - 1;

  typedef enum logic [2:0] {
    C_HOLD_D,
    C_HOLD_R,
    C_FLUSH,
    C_INTLK,
    C_IMISS,
    C_RUN
  } case_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [STAGES-1:1] vld_p0;
  logic [STAGES-1:1] vld_nxt;
  logic [STAGES-1:0] vld_all;
  logic              dstall;
  logic              wbr;
  logic              lu;
  logic              src_a_hit;
  logic              src_b_hit;
  logic              stall_evt;
  logic              retire_ok;
  case_t             sel;

  // IF always holds a live fetch, so bit 0 is tied high and feeds the shift uniformly
  assign vld_all     = {vld_p0, 1'b1};
  assign stage_valid = vld_all;

  assign src_a_hit = id_src_a_used && (id_src_a == ex_dest);
  assign src_b_hit = id_src_b_used && (id_src_b == ex_dest);
  assign dstall    = vld_all[MEM_STAGE] && d_mem_req && !d_mem_resp;
  assign wbr       = vld_all[WB] && redirect;
  assign lu        = vld_all[1] && vld_all[2] && ex_load && (src_a_hit || src_b_hit);

  assign i_mem_read = !dstall;

  // Priority: a D-stall masks everything; a redirect waits for the fetch in flight
  always_comb begin
    if (dstall)               sel = C_HOLD_D;
    else if (wbr && !i_mem_resp) sel = C_HOLD_R;
    else if (wbr)             sel = C_FLUSH;
    else if (lu)              sel = C_INTLK;
    else if (!i_mem_resp)     sel = C_IMISS;
    else                      sel = C_RUN;
  end

  assign stall_evt = (sel == C_HOLD_D) || (sel == C_HOLD_R) ||
                     (sel == C_INTLK)  || (sel == C_IMISS);
  assign retire_ok = (sel != C_HOLD_D) && (sel != C_HOLD_R);
  assign retire    = !reset && retire_ok && vld_p0[WB];

  always_comb begin
    stage_load = '1;
    bubble     = '0;
    vld_nxt    = vld_p0;
    unique case (sel)
      C_HOLD_D, C_HOLD_R: stage_load = '0;
      C_FLUSH: begin
        bubble    = '1;
        bubble[0] = 1'b0;
        vld_nxt   = '0;
      end
      C_INTLK: begin
        stage_load[1:0] = 2'b00;
        bubble[2]       = 1'b1;
        vld_nxt[2]      = 1'b0;
        for (int k = 3; k < STAGES; k++) vld_nxt[k] = vld_all[k-1];
      end
      C_IMISS: begin
        stage_load[0] = 1'b0;
        bubble[1]     = 1'b1;
        vld_nxt[1]    = 1'b0;
        for (int k = 2; k < STAGES; k++) vld_nxt[k] = vld_all[k-1];
      end
      default: begin
        for (int k = 1; k < STAGES; k++) vld_nxt[k] = vld_all[k-1];
      end
    endcase
    // While reset is held every register loads a NOP so the datapath starts clean
    if (reset) begin
      stage_load = '1;
      bubble     = '1;
      bubble[0]  = 1'b0;
    end
  end

  // Stage-state and counter update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0     <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      vld_p0 <= vld_nxt;
      if (stall_evt)     stall_cnt  <= sat_inc(stall_cnt);
      if (sel == C_FLUSH) flush_cnt <= sat_inc(flush_cnt);
      if (retire)        retire_cnt <= sat_inc(retire_cnt);
    end
  end

endmodule
